flex_pts_buf_tx: RTL

Parametrised buffered parallel-to-serial transmitter for the USB/SD TX datapath. It is the successor to the basic flex PTS shift register. It accepts words through a small valid/ready FIFO and serialises them LSB- or MSB-first, with a programmable number of clocks per bit. Consecutive buffered words go out with no idle gap, and a stall input freezes the bit timer mid-bit. It sits between the packet encoder (word source) and the line encoder (bit sink).

---
 rtl/flex_pts_buf_tx_if.sv | 34 +++
 rtl/flex_pts_buf_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/flex_pts_buf_tx_if.sv
// ============================================================
// flex_pts_buf_tx_if : word load / serial output bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface flex_pts_buf_tx_if #(
   parameter int NUM_BITS = 8,
   parameter int DEPTH    = 4
);
   localparam int c_CW = $clog2(DEPTH + 1);

   logic [NUM_BITS-1:0] load_data;
   logic                load_valid;
   logic                load_ready;
   logic                stall;
   logic                serial_out;
   logic                serial_valid;
   logic                bit_strobe;
   logic                busy;
   logic [c_CW-1:0]     fifo_count;

   modport master (
      output load_data, load_valid, stall,
      input  load_ready, serial_out, serial_valid, bit_strobe, busy, fifo_count
   );

   modport slave (
      input  load_data, load_valid, stall,
      output load_ready, serial_out, serial_valid, bit_strobe, busy, fifo_count
   );
endinterface

`default_nettype wire

// File: rtl/flex_pts_buf_tx.sv
// ============================================================
// flex_pts_buf_tx : FIFO-buffered parallel-to-serial transmitter
// Rev 1.0
// ============================================================
`default_nettype none

module flex_pts_buf_tx #(
   parameter int NUM_BITS   = 8,
   parameter int SHIFT_MSB  = 0,
   parameter int DEPTH      = 4,
   parameter int BIT_PERIOD = 8
) (
   input  wire logic           clk,
   input  wire logic           rst,
   flex_pts_buf_tx_if.slave    bus
);

   localparam int c_CW = $clog2(DEPTH + 1);
   localparam int c_PW = $clog2(DEPTH);
   localparam int c_TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int c_IW = $clog2(NUM_BITS);
   localparam logic [c_TW-1:0] c_T_LAST = c_TW'(BIT_PERIOD - 1);
   localparam logic [c_IW-1:0] c_I_LAST = c_IW'(NUM_BITS - 1);
   localparam logic [c_CW-1:0] c_DEPTH  = c_CW'(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // ---------------- FIFO ----------------
   logic [NUM_BITS-1:0] r_mem [DEPTH];
   logic [c_PW-1:0]     r_wr_ptr;
   logic [c_PW-1:0]     r_rd_ptr;
   logic [c_CW-1:0]     r_count;
   logic                w_load_ready;
   logic                w_push;
   logic                w_pop;
   logic                w_fifo_nempty;
   logic [NUM_BITS-1:0] w_head;

   // Readiness looks at the registered count only, so a same-cycle pop never frees a slot.
   assign w_load_ready  = (r_count < c_DEPTH) && !rst;
   assign w_push        = bus.load_valid && w_load_ready;
   assign w_fifo_nempty = (r_count != '0);
   assign w_head        = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------- Shifter ----------------
   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_BITS-1:0] r_shreg;
   logic [NUM_BITS-1:0] w_shreg_nxt;
   logic [NUM_BITS-1:0] w_shifted;
   logic [c_TW-1:0]     r_timer;
   logic [c_TW-1:0]     w_timer_nxt;
   logic [c_IW-1:0]     r_idx;
   logic [c_IW-1:0]     w_idx_nxt;
   logic                w_strobe_nxt;
   logic                w_out_nxt;
   logic                r_serial_out;
   logic                r_serial_valid;
   logic                r_bit_strobe;

   generate
      if (SHIFT_MSB != 0) begin : g_msb_first
         assign w_shifted = {r_shreg[NUM_BITS-2:0], 1'b0};
         assign w_out_nxt = w_shreg_nxt[NUM_BITS-1];
      end else begin : g_lsb_first
         assign w_shifted = {1'b0, r_shreg[NUM_BITS-1:1]};
         assign w_out_nxt = w_shreg_nxt[0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_timer <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_timer <= w_timer_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_shreg_nxt  = r_shreg;
      w_timer_nxt  = r_timer;
      w_idx_nxt    = r_idx;
      w_pop        = 1'b0;
      w_strobe_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_fifo_nempty && !bus.stall) begin
               w_pop        = 1'b1;
               w_shreg_nxt  = w_head;
               w_timer_nxt  = '0;
               w_idx_nxt    = '0;
               w_strobe_nxt = 1'b1;
               w_state_nxt  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!bus.stall) begin
               if (r_timer == c_T_LAST) begin
                  w_timer_nxt = '0;
                  if (r_idx != c_I_LAST) begin
                     w_shreg_nxt  = w_shifted;
                     w_idx_nxt    = r_idx + c_IW'(1);
                     w_strobe_nxt = 1'b1;
                  end else if (w_fifo_nempty) begin
                     // Gapless reload: next word's bit 0 follows directly.
                     w_pop        = 1'b1;
                     w_shreg_nxt  = w_head;
                     w_idx_nxt    = '0;
                     w_strobe_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_timer_nxt = r_timer + c_TW'(1);
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_serial_out   <= 1'b1;
         r_serial_valid <= 1'b0;
         r_bit_strobe   <= 1'b0;
      end else begin
         r_serial_out   <= (w_state_nxt == ST_SHIFT) ? w_out_nxt : 1'b1;
         r_serial_valid <= (w_state_nxt == ST_SHIFT);
         r_bit_strobe   <= w_strobe_nxt;
      end
   end

   assign bus.load_ready   = w_load_ready;
   assign bus.serial_out   = r_serial_out;
   assign bus.serial_valid = r_serial_valid;
   assign bus.bit_strobe   = r_bit_strobe;
   assign bus.busy         = r_serial_valid || w_fifo_nempty;
   assign bus.fifo_count   = r_count;

endmodule

`default_nettype wire
